// File: rtl/wb_timer_if.sv
// rtl/wb_timer_if.sv - Wishbone-style request/acknowledge bundle for wb_timer
interface wb_timer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] Wb_addr;
  logic                  Wb_cs;
  logic                  Wb_we;
  logic [DATA_WIDTH-1:0] Wb_wdata;
  logic [DATA_WIDTH-1:0] Wb_rdata;
  logic                  Wb_ack;

  modport master (
    output Wb_addr, Wb_cs, Wb_we, Wb_wdata,
    input  Wb_rdata, Wb_ack
  );

  modport slave (
    input  Wb_addr, Wb_cs, Wb_we, Wb_wdata,
    output Wb_rdata, Wb_ack
  );
endinterface

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - prescaled 32-bit timer with compare match, auto-reload and level irq
module wb_timer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic       Clk,
  input  logic       Rst,
  wb_timer_if.slave  wb,
  output logic       Irq
);
  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_COUNT   = 2'd1;
  localparam logic [1:0] SEL_COMPARE = 2'd2;
  localparam logic [1:0] SEL_STATUS  = 2'd3;

  state_t                state;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  ctrl_en;
  logic                  ctrl_irq_en;
  logic                  ctrl_auto;
  logic [7:0]            prescale;
  logic [7:0]            prescnt;
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] compare;
  logic                  status;

  logic                  hit;
  logic                  accept;
  logic [1:0]            sel;
  logic                  wr_ctrl;
  logic                  wr_count;
  logic                  wr_compare;
  logic                  wr_status;
  logic                  tick;
  logic                  match;
  logic [DATA_WIDTH-1:0] read_val;

  assign hit    = wb.Wb_cs && (wb.Wb_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign accept = hit && (state == IDLE);
  assign sel    = wb.Wb_addr[3:2];

  assign wr_ctrl    = accept && wb.Wb_we && (sel == SEL_CTRL);
  assign wr_count   = accept && wb.Wb_we && (sel == SEL_COUNT);
  assign wr_compare = accept && wb.Wb_we && (sel == SEL_COMPARE);
  assign wr_status  = accept && wb.Wb_we && (sel == SEL_STATUS);

  assign tick  = ctrl_en && (prescnt == prescale);
  // A COUNT write at the same edge overrides the tick, including its match.
  assign match = tick && (count == compare) && !wr_count;

  always_comb begin
    read_val = '0;
    case (sel)
      SEL_CTRL: begin
        read_val[0]    = ctrl_en;
        read_val[1]    = ctrl_irq_en;
        read_val[2]    = ctrl_auto;
        read_val[15:8] = prescale;
      end
      SEL_COUNT:   read_val = count;
      SEL_COMPARE: read_val = compare;
      default:     read_val[0] = status;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      rdata <= '0;
    end else if (state == IDLE) begin
      if (hit) begin
        state <= ACK;
        ack   <= 1'b1;
        rdata <= wb.Wb_we ? '0 : read_val;
      end
    end else begin
      // A request still held here is the transfer being acknowledged.
      state <= IDLE;
      ack   <= 1'b0;
      rdata <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_auto   <= 1'b0;
      prescale    <= 8'd0;
      prescnt     <= 8'd0;
      count       <= '0;
      compare     <= '1;
      status      <= 1'b0;
      Irq         <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= wb.Wb_wdata[0];
        ctrl_irq_en <= wb.Wb_wdata[1];
        ctrl_auto   <= wb.Wb_wdata[2];
        prescale    <= wb.Wb_wdata[15:8];
      end

      if (wr_ctrl || !ctrl_en || tick) begin
        prescnt <= 8'd0;
      end else begin
        prescnt <= prescnt + 8'd1;
      end

      if (wr_count) begin
        count <= wb.Wb_wdata;
      end else if (tick) begin
        if ((count == compare) && ctrl_auto) begin
          count <= '0;
        end else begin
          count <= count + DATA_WIDTH'(1);
        end
      end

      if (wr_compare) begin
        compare <= wb.Wb_wdata;
      end

      // Setting wins over a same-edge write-1 clear so no match is lost.
      if (match) begin
        status <= 1'b1;
      end else if (wr_status && wb.Wb_wdata[0]) begin
        status <= 1'b0;
      end

      Irq <= status && ctrl_irq_en;
    end
  end

  assign wb.Wb_ack   = ack;
  assign wb.Wb_rdata = rdata;
endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - randomized bench for wb_timer against a cycle-level reference model
module tb_wb_timer;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;
  int   vectors = 0;
  int   miscompares = 0;

  wb_timer_if bus ();

  wb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .Clk(clk),
    .Rst(rst),
    .wb (bus),
    .Irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents and bus outputs after each rising edge.
  bit        m_en, m_irqen, m_auto, m_status, m_irq, m_ack;
  int        m_psc, m_pres;
  bit [31:0] m_count, m_cmp, m_rdata;

  function automatic bit [31:0] model_read(input int idx);
    bit [31:0] v = 0;
    case (idx)
      0: v = {16'd0, m_psc[7:0], 5'd0, m_auto, m_irqen, m_en};
      1: v = m_count;
      2: v = m_cmp;
      default: v = {31'd0, m_status};
    endcase
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit        acc, wr, tk, setm;
    int        idx;
    bit [31:0] rv, wd;
    if (!rst) begin
      m_en = 0; m_irqen = 0; m_auto = 0; m_psc = 0; m_pres = 0;
      m_count = 0; m_cmp = 32'hFFFF_FFFF; m_status = 0; m_irq = 0;
      m_ack = 0; m_rdata = 0;
    end else begin
      acc  = bus.Wb_cs && ((bus.Wb_addr >> 4) == (BASE >> 4)) && !m_ack;
      wr   = acc && bus.Wb_we;
      idx  = int'(bus.Wb_addr[3:2]);
      wd   = bus.Wb_wdata;
      rv   = model_read(idx);
      m_irq = m_status && m_irqen;
      tk   = m_en && (m_pres == m_psc);
      m_pres = (!m_en || tk) ? 0 : m_pres + 1;
      setm = 0;
      if (wr && idx == 1) m_count = wd;
      else if (tk) begin
        if (m_count == m_cmp) begin
          setm = 1;
          m_count = m_auto ? 0 : m_count + 1;
        end else m_count = m_count + 1;
      end
      if (wr && idx == 3 && wd[0]) m_status = 0;
      if (setm) m_status = 1;
      if (wr && idx == 2) m_cmp = wd;
      if (wr && idx == 0) begin
        m_en = wd[0]; m_irqen = wd[1]; m_auto = wd[2]; m_psc = int'(wd[15:8]); m_pres = 0;
      end
      m_rdata = (acc && !bus.Wb_we) ? rv : 0;
      m_ack = acc;
    end
  end

  always @(posedge clk) begin
    #1;
    check("ack", {31'd0, bus.Wb_ack}, {31'd0, m_ack});
    check("rdata", bus.Wb_rdata, m_rdata);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    bus.Wb_cs = 1'b1; bus.Wb_we = w; bus.Wb_addr = a; bus.Wb_wdata = d;
    lat = 0; rd = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (bus.Wb_ack) begin
        lat = i; rd = bus.Wb_rdata;
        break;
      end
    end
    bus.Wb_cs = 1'b0; bus.Wb_we = 1'b0;
    if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; int lat;
    xfer(1'b1, a, d, rd, lat);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    int lat;
    xfer(1'b0, a, 32'd0, v, lat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, d, a;
    int lat, acks, seen;
    bus.Wb_cs = 0; bus.Wb_we = 0; bus.Wb_addr = 0; bus.Wb_wdata = 0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Reset values and acknowledge latency
    xfer(1'b0, BASE + 32'h8, 32'd0, v, lat);
    check("ack_latency", lat, 32'd1);
    check("reset_compare", v, 32'hFFFF_FFFF);
    rd(BASE, v);
    check("reset_ctrl", v, 32'd0);
    rd(BASE + 32'hC, v);
    check("reset_status", v, 32'd0);

    // Compare match with irq at full rate
    wr(BASE + 32'h8, 32'd5);
    wr(BASE, 32'h3);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin @(posedge clk); #1; seen = irq; end
    check("irq_rise", seen, 32'd1);
    rd(BASE + 32'hC, v);
    check("match_flag", v, 32'd1);
    wr(BASE + 32'hC, 32'h1);
    @(posedge clk); #1;
    check("irq_clear", {31'd0, irq}, 32'd0);

    // Prescale 3 with auto-reload at compare 2
    wr(BASE, 32'h0);
    wr(BASE + 32'hC, 32'h1);
    wr(BASE + 32'h4, 32'd0);
    wr(BASE + 32'h8, 32'd2);
    wr(BASE, 32'h0000_0307);
    for (int i = 0; i < 12; i++) begin
      rd(BASE + 32'h4, v);
      check("reload_range", {31'd0, v <= 32'd2}, 32'd1);
    end
    rd(BASE + 32'hC, v);
    check("reload_flag", v, 32'd1);

    // Wrap at all-ones does not raise the flag
    wr(BASE, 32'h0);
    wr(BASE + 32'hC, 32'h1);
    wr(BASE + 32'h8, 32'd10);
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    wr(BASE, 32'h1);
    rd(BASE + 32'hC, v);
    check("wrap_no_flag", v, 32'd0);
    rd(BASE + 32'h4, v);
    check("wrap_count", {31'd0, v < 32'd10}, 32'd1);

    // Held out-of-window request is ignored
    wr(BASE, 32'h0);
    bus.Wb_cs = 1; bus.Wb_we = 1; bus.Wb_addr = 32'h2000 + 32'h8; bus.Wb_wdata = 32'h1234;
    acks = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; acks += int'(bus.Wb_ack); end
    bus.Wb_cs = 0; bus.Wb_we = 0;
    check("miss_acks", acks, 32'd0);
    rd(BASE + 32'h8, v);
    check("miss_compare", v, 32'd10);

    // COUNT write coinciding with a matching tick
    wr(BASE + 32'hC, 32'h1);
    wr(BASE + 32'h4, 32'd3);
    wr(BASE + 32'h8, 32'd3);
    wr(BASE, 32'h0000_0101);
    wr(BASE + 32'h4, 32'h100);
    rd(BASE + 32'hC, v);
    check("wr_beats_tick_flag", v, 32'd0);
    rd(BASE + 32'h4, v);
    check("wr_beats_tick_count", {31'd0, v >= 32'h100 && v < 32'h110}, 32'd1);

    // Reset asserted at the accept edge of a COMPARE write
    bus.Wb_cs = 1; bus.Wb_we = 1; bus.Wb_addr = BASE + 32'h8; bus.Wb_wdata = 32'h55;
    rst = 0;
    @(posedge clk); #1;
    check("rst_no_ack", {31'd0, bus.Wb_ack}, 32'd0);
    bus.Wb_cs = 0; bus.Wb_we = 0;
    @(posedge clk); #1;
    rst = 1;
    rd(BASE + 32'h8, v);
    check("rst_compare", v, 32'hFFFF_FFFF);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 19);
      if (kind < 12) begin
        int r;
        r = $urandom_range(0, 3);
        a = BASE + (r << 2) + $urandom_range(0, 3);
        d = $urandom;
        case (r)
          0: d[15:8] = 8'($urandom_range(0, 3));
          1: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 15);
          2: d = $urandom_range(0, 15);
          default: ;
        endcase
        xfer($urandom_range(0, 1) == 1, a, d, v, lat);
      end else if (kind < 15) begin
        a = $urandom;
        if (a[31:4] == BASE[31:4]) a[12] = ~a[12];
        bus.Wb_cs = 1; bus.Wb_we = $urandom_range(0, 1) == 1; bus.Wb_addr = a; bus.Wb_wdata = $urandom;
        idle($urandom_range(1, 3));
        bus.Wb_cs = 0; bus.Wb_we = 0;
      end else if (kind < 19) begin
        idle($urandom_range(0, 5));
      end else begin
        rst = 0;
        idle(1);
        rst = 1;
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
